// File: rtl/rv_if_pkg.sv
// Shared definitions for the rv_if fetch stage: NOP encoding, FSM states, FIFO entry layout.
package rv_if_pkg;

    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRY_W = 2 * XLEN;

    typedef enum logic [1:0] {
        IF_ST_REQ  = 2'd0,
        IF_ST_WAIT = 2'd1,
        IF_ST_DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] ins;
    } if_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv_if_fifo.sv
// Prefetch FIFO: power-of-two depth, head always visible, flush wins over push and pop.
module rv_if_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rv_if.sv
// Instruction fetch stage: owns the fetch PC, keeps one memory request in flight,
// buffers returned words in a prefetch FIFO and handles EX redirects.
module rv_if
    import rv_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IF2MEM_REQ,
    output logic [31:0] IF2MEM_ADDR,
    input  logic        MEM2IF_GNT,
    input  logic        MEM2IF_RVALID,
    input  logic [31:0] MEM2IF_RDATA,
    input  logic        EX2IF_JUMP_EN,
    input  logic [31:0] EX2IF_JUMP_ADDR,
    input  logic        ID2IF_STALL,
    output logic [31:0] IF2ID_ADDR,
    output logic [31:0] IF2ID_INS,
    output logic        IF2ID_VALID,
    output logic        IF2ID_WASH
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    if_state_e      state_q;
    if_state_e      state_d;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    fetch_pc_d;
    logic [31:0]    req_pc_q;
    logic [31:0]    req_pc_d;

    logic           req_c;
    logic           push_c;
    logic           pop_c;
    logic           space_after_push_c;
    if_entry_t      push_entry;
    if_entry_t      head_entry;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;

    assign pop_c = !fifo_empty && !ID2IF_STALL && !EX2IF_JUMP_EN;

    // A pop in the same cycle keeps the slot of the word being pushed free.
    assign space_after_push_c = pop_c || (fifo_count < CW'(FIFO_DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_c      = 1'b0;
        push_c     = 1'b0;

        case (state_q)
            IF_ST_REQ: begin
                req_c = !fifo_full && !EX2IF_JUMP_EN;
                if (req_c && MEM2IF_GNT) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = IF_ST_WAIT;
                end
            end
            IF_ST_WAIT: begin
                if (MEM2IF_RVALID) begin
                    if (EX2IF_JUMP_EN) begin
                        state_d = IF_ST_REQ;
                    end else begin
                        push_c = 1'b1;
                        req_c  = space_after_push_c;
                        if (req_c && MEM2IF_GNT) begin
                            req_pc_d   = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                            state_d    = IF_ST_WAIT;
                        end else begin
                            state_d = IF_ST_REQ;
                        end
                    end
                end else if (EX2IF_JUMP_EN) begin
                    state_d = IF_ST_DROP;
                end
            end
            IF_ST_DROP: begin
                // The stale response closes the drop even if another redirect lands on it.
                if (MEM2IF_RVALID) begin
                    state_d = IF_ST_REQ;
                end
            end
            default: begin
                state_d = IF_ST_REQ;
            end
        endcase

        if (EX2IF_JUMP_EN) begin
            fetch_pc_d = word_align(EX2IF_JUMP_ADDR);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IF_ST_REQ;
            fetch_pc_q <= word_align(RESET_PC);
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign push_entry.addr = req_pc_q;
    assign push_entry.ins  = MEM2IF_RDATA;
    assign push_data       = push_entry;
    assign head_entry      = head_data;

    rv_if_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (EX2IF_JUMP_EN),
        .data_i  (push_data),
        .head_o  (head_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign IF2MEM_REQ  = req_c && !RST;
    assign IF2MEM_ADDR = fetch_pc_q;
    assign IF2ID_VALID = !fifo_empty;
    assign IF2ID_INS   = fifo_empty ? RV_NOP : head_entry.ins;
    assign IF2ID_ADDR  = fifo_empty ? 32'h0 : head_entry.addr;
    assign IF2ID_WASH  = EX2IF_JUMP_EN;

endmodule

// File: tb/tb_rv_if.sv
// Bench for rv_if: memory models, a stream scoreboard for presented instructions,
// and directed plus random scenarios.
`timescale 1ns/1ps
module tb_rv_if;

    localparam logic [31:0] NOP_EXP = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        CLK;
    logic        RST;
    logic        req, gnt, rvalid;
    logic [31:0] maddr, rdata;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        stall;
    logic [31:0] id_addr, id_ins;
    logic        id_valid, id_wash;

    logic        req2, gnt2, rvalid2, jump2, stall2;
    logic [31:0] maddr2, rdata2, jaddr2, id_addr2, id_ins2;
    logic        id_valid2, id_wash2;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] mon_exp = 32'h0;

    assign gnt2   = 1'b1;
    assign jump2  = 1'b0;
    assign stall2 = 1'b0;
    assign jaddr2 = 32'h0;

    rv_if #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .IF2MEM_REQ(req), .IF2MEM_ADDR(maddr),
        .MEM2IF_GNT(gnt), .MEM2IF_RVALID(rvalid), .MEM2IF_RDATA(rdata),
        .EX2IF_JUMP_EN(jump_en), .EX2IF_JUMP_ADDR(jump_addr),
        .ID2IF_STALL(stall),
        .IF2ID_ADDR(id_addr), .IF2ID_INS(id_ins),
        .IF2ID_VALID(id_valid), .IF2ID_WASH(id_wash)
    );

    rv_if #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) dut_wrap (
        .CLK(CLK), .RST(RST),
        .IF2MEM_REQ(req2), .IF2MEM_ADDR(maddr2),
        .MEM2IF_GNT(gnt2), .MEM2IF_RVALID(rvalid2), .MEM2IF_RDATA(rdata2),
        .EX2IF_JUMP_EN(jump2), .EX2IF_JUMP_ADDR(jaddr2),
        .ID2IF_STALL(stall2),
        .IF2ID_ADDR(id_addr2), .IF2ID_INS(id_ins2),
        .IF2ID_VALID(id_valid2), .IF2ID_WASH(id_wash2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory for the main instance: random grant, random latency, one response per grant.
    initial begin : mem_main
        logic        fire;
        logic        pend;
        logic [31:0] faddr;
        logic [31:0] paddr;
        int          wcnt;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        pend = 1'b0; paddr = 32'h0; wcnt = 0;
        forever begin
            @(negedge CLK);
            fire  = req && gnt && !RST;
            faddr = maddr;
            if (fire) begin
                checks++;
                if (pend || faddr[1:0] != 2'b00) begin
                    errors++;
                    $display("FAIL mem_request: addr %h granted, outstanding=%0b (required none outstanding, aligned)", faddr, pend);
                end
            end
            @(posedge CLK);
            #1;
            rvalid = 1'b0;
            if (RST) begin
                pend = 1'b0;
            end else begin
                if (fire) begin
                    pend  = 1'b1;
                    paddr = faddr;
                    wcnt  = int'($urandom_range(lat_max, lat_min));
                end
                if (pend) begin
                    wcnt--;
                    if (wcnt <= 0) begin
                        rvalid = 1'b1;
                        rdata  = ins_of(paddr);
                        pend   = 1'b0;
                    end
                end
            end
            gnt = (int'($urandom_range(99)) < gnt_pct);
        end
    end

    // Single-cycle memory for the wrap instance.
    initial begin : mem_wrap
        logic        fire2;
        logic [31:0] a2;
        rvalid2 = 1'b0; rdata2 = 32'h0;
        forever begin
            @(negedge CLK);
            fire2 = req2 && !RST;
            a2    = maddr2;
            @(posedge CLK);
            #1;
            rvalid2 = fire2 && !RST;
            rdata2  = ins_of(a2);
        end
    end

    // Scoreboard: consumed instructions must follow the sequential PC stream from the last redirect.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_exp = 32'h0;
            end else begin
                checks++;
                if (id_wash !== jump_en) begin
                    errors++;
                    $display("FAIL wash_follow: wash=%b required %b", id_wash, jump_en);
                end
                if (!id_valid) begin
                    checks++;
                    if (id_ins !== NOP_EXP) begin
                        errors++;
                        $display("FAIL nop_when_empty: ins=%h required %h", id_ins, NOP_EXP);
                    end
                end
                if (id_valid && !stall && !jump_en) begin
                    checks++;
                    if (id_addr !== mon_exp || id_ins !== ins_of(mon_exp)) begin
                        errors++;
                        $display("FAIL stream_order: addr=%h ins=%h required addr=%h ins=%h", id_addr, id_ins, mon_exp, ins_of(mon_exp));
                    end
                    mon_exp = mon_exp + 32'd4;
                    pops++;
                end
                if (jump_en) begin
                    mon_exp = jump_addr & 32'hFFFF_FFFC;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        next_cycle();
        RST = 1'b1; stall = 1'b0; jump_en = 1'b0;
        repeat (2) next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        gnt_pct = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++;
            if (req !== 1'b1 || maddr !== 32'h0) begin
                errors++;
                $display("FAIL reset_req: cycle %0d req=%b addr=%h required req=1 addr=0", k, req, maddr);
            end
            checks++;
            if (id_valid !== 1'b0 || id_ins !== NOP_EXP || id_addr !== 32'h0) begin
                errors++;
                $display("FAIL reset_id: valid=%b ins=%h addr=%h required 0/%h/0", id_valid, id_ins, id_addr, NOP_EXP);
            end
            next_cycle();
        end
    endtask

    task automatic test_zero_wait();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            sample();
            checks++;
            if (req !== 1'b1 || maddr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL zw_request: cycle %0d req=%b addr=%h required req=1 addr=%h", k, req, maddr, 32'(4 * k));
            end
            if (k >= 2) begin
                checks++;
                if (id_valid !== 1'b1 || id_addr !== 32'(4 * (k - 2))) begin
                    errors++;
                    $display("FAIL zw_present: cycle %0d valid=%b addr=%h required valid=1 addr=%h", k, id_valid, id_addr, 32'(4 * (k - 2)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (i >= 1) begin
                checks++;
                if (req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_req: stall cycle %0d req=%b required 0", i, req);
                end
            end
            checks++;
            if (id_valid !== 1'b1 || id_addr !== mon_exp) begin
                errors++;
                $display("FAIL stall_hold: stall cycle %0d valid=%b addr=%h required valid=1 addr=%h", i, id_valid, id_addr, mon_exp);
            end
            next_cycle();
        end
        stall = 1'b0;
        sample();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_req: req=%b required 0 in pop cycle", req);
        end
        next_cycle();
        sample();
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume_req: req=%b required 1 after pop", req);
        end
        repeat (8) next_cycle();
    endtask

    task automatic test_jump_wait();
        bit found;
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        next_cycle();
        jump_en = 1'b1; jump_addr = 32'h0000_0103;
        sample();
        checks++;
        if (id_wash !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL jw_jump_cycle: wash=%b req=%b required wash=1 req=0", id_wash, req);
        end
        next_cycle();
        jump_en = 1'b0;
        sample();
        checks++;
        if (id_wash !== 1'b0 || req !== 1'b0 || maddr !== 32'h100 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL jw_drop: wash=%b req=%b addr=%h valid=%b required 0/0/100/0", id_wash, req, maddr, id_valid);
        end
        repeat (2) next_cycle();
        sample();
        checks++;
        if (req !== 1'b1 || maddr !== 32'h100 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL jw_refetch: req=%b addr=%h valid=%b required 1/100/0", req, maddr, id_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            sample();
            found = id_valid;
        end
        checks++;
        if (!found || id_addr !== 32'h100) begin
            errors++;
            $display("FAIL jw_first: found=%b addr=%h required found=1 addr=100", found, id_addr);
        end
        next_cycle();
    endtask

    task automatic test_jump_rvalid();
        logic [31:0] tgt;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (4) next_cycle();
        jump_addr = $urandom | 32'h1;
        tgt = jump_addr & 32'hFFFF_FFFC;
        jump_en = 1'b1;
        sample();
        checks++;
        if (id_wash !== 1'b1 || req !== 1'b0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL jr_jump_cycle: wash=%b req=%b rvalid=%b required 1/0/1", id_wash, req, rvalid);
        end
        next_cycle();
        jump_en = 1'b0;
        sample();
        checks++;
        if (id_valid !== 1'b0 || req !== 1'b1 || maddr !== tgt) begin
            errors++;
            $display("FAIL jr_after: valid=%b req=%b addr=%h required 0/1/%h", id_valid, req, maddr, tgt);
        end
        next_cycle();
        sample();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL jr_no_stale: valid=%b addr=%h required valid=0", id_valid, id_addr);
        end
        next_cycle();
        sample();
        checks++;
        if (id_valid !== 1'b1 || id_addr !== tgt || id_ins !== ins_of(tgt)) begin
            errors++;
            $display("FAIL jr_target: valid=%b addr=%h ins=%h required 1/%h/%h", id_valid, id_addr, id_ins, tgt, ins_of(tgt));
        end
        next_cycle();
    endtask

    task automatic test_gnt_withheld();
        bit found;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) next_cycle();
        sample();
        gnt_pct = 0;
        for (int c = 4; c < 8; c++) begin
            next_cycle();
            sample();
            checks++;
            if (req !== 1'b1 || maddr !== 32'h10) begin
                errors++;
                $display("FAIL gw_hold: cycle %0d req=%b addr=%h required 1/10", c, req, maddr);
            end
            if (c >= 6) begin
                checks++;
                if (id_valid !== 1'b0 || id_ins !== NOP_EXP) begin
                    errors++;
                    $display("FAIL gw_drained: cycle %0d valid=%b ins=%h required 0/%h", c, id_valid, id_ins, NOP_EXP);
                end
            end
        end
        gnt_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            next_cycle();
            sample();
            found = id_valid;
        end
        checks++;
        if (!found || id_addr !== 32'h10) begin
            errors++;
            $display("FAIL gw_resume: found=%b addr=%h required found=1 addr=10", found, id_addr);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) next_cycle();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (maddr !== 32'h0 || id_valid !== 1'b0 || id_ins !== NOP_EXP || id_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: addr=%h valid=%b ins=%h id_addr=%h required 0/0/%h/0", maddr, id_valid, id_ins, id_addr, NOP_EXP);
        end
        checks++;
        if (maddr2 !== WRAP_PC || id_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_wrap: addr=%h valid=%b required %h/0", maddr2, id_valid2, WRAP_PC);
        end
        repeat (2) next_cycle();
        RST = 1'b0;
        sample();
        checks++;
        if (req !== 1'b1 || maddr !== 32'h0) begin
            errors++;
            $display("FAIL async_release: req=%b addr=%h required 1/0", req, maddr);
        end
        next_cycle();
    endtask

    task automatic test_pc_wrap();
        logic [31:0] e;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sample();
            if (k <= 2) begin
                e = WRAP_PC + 32'(4 * k);
                checks++;
                if (req2 !== 1'b1 || maddr2 !== e) begin
                    errors++;
                    $display("FAIL wrap_request: cycle %0d req=%b addr=%h required 1/%h", k, req2, maddr2, e);
                end
            end
            if (k >= 2) begin
                e = WRAP_PC + 32'(4 * (k - 2));
                checks++;
                if (id_valid2 !== 1'b1 || id_addr2 !== e || id_ins2 !== ins_of(e) || id_wash2 !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_present: cycle %0d valid=%b addr=%h ins=%h required 1/%h/%h", k, id_valid2, id_addr2, id_ins2, e, ins_of(e));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int  pops_start;
        logic prev_jump;
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        do_reset();
        pops_start = pops;
        prev_jump = 1'b0;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(99) < 30);
            jump_en = !prev_jump && ($urandom_range(99) < 6);
            jump_addr = $urandom;
            prev_jump = jump_en;
            next_cycle();
        end
        stall = 1'b0; jump_en = 1'b0;
        repeat (40) next_cycle();
        checks++;
        if (pops - pops_start < 30) begin
            errors++;
            $display("FAIL random_progress: consumed=%0d required at least 30", pops - pops_start);
        end
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_jump_wait();
        test_jump_rvalid();
        test_gnt_withheld();
        test_async_reset();
        test_pc_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
